// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment type and BCD glyph constants
// Purpose: segment vector type plus the active-high glyphs for BCD 0-9 and blank.
// Bit order of seg_t is {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_scan_bcd.sv
// rtl/seven_seg_scan_bcd.sv - combinational BCD to seven-segment decoder
// Purpose: maps one BCD nibble to its segment glyph; codes 10-15 are blank.
// Ports:
//   i_bcd  in  4  BCD code
//   o_seg  out 7  active-high segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment display scanner
// Purpose: time-multiplexes DIGIT_COUNT BCD digits onto one segment bus, with a
// shadow/pending scheme so new values only appear at frame boundaries.
// Optional feature: define SEVEN_SEG_LZ_BLANK_EN to blank leading zeros.
// Ports:
//   clk       in   1               clock
//   rst       in   1               synchronous active-high reset
//   load      in   1               strobe, captures digits
//   digits    in   DIGIT_COUNT*4   packed BCD, index 0 least significant
//   anode     out  DIGIT_COUNT     one-hot digit enable
//   segments  out  7               active-high segments {g,f,e,d,c,b,a}
//   frame     out  1               pulse on the cycle the scan index returns to 0
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_COUNT = 4,
  parameter int PRESCALE    = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DIGIT_COUNT-1:0][3:0] digits,
  output logic [DIGIT_COUNT-1:0]      anode,
  output seg_t                        segments,
  output logic                        frame
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  logic [PW-1:0]                 r_presc;
  logic [IW-1:0]                 r_idx;
  logic [DIGIT_COUNT-1:0][3:0]   r_shadow;
  logic [DIGIT_COUNT-1:0][3:0]   r_disp;
  logic                          r_pending;
  logic [DIGIT_COUNT-1:0]        r_anode;
  seg_t                          r_segments;
  logic                          r_frame;

  logic                          w_tc;
  logic                          w_wrap;
  logic [IW-1:0]                 w_idx_next;
  logic [DIGIT_COUNT-1:0][3:0]   w_disp_next;
  logic [3:0]                    w_sel_digit;
  seg_t                          w_dec_seg;
  logic                          w_blank;

  assign w_tc   = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap = w_tc && (r_idx == IW'(DIGIT_COUNT - 1));

  always_comb begin
    w_idx_next = r_idx;
    if (w_tc) begin
      w_idx_next = (r_idx == IW'(DIGIT_COUNT - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // A load landing on the wrap edge bypasses the shadow so it shows this frame.
  always_comb begin
    w_disp_next = r_disp;
    if (w_wrap && load) begin
      w_disp_next = digits;
    end else if (w_wrap && r_pending) begin
      w_disp_next = r_shadow;
    end
  end

  // Decode the digit that will be lit after this edge, so anode and segments
  // are registered together.
  assign w_sel_digit = w_disp_next[w_idx_next];

  bcd_to_7seg u_dec (
    .i_bcd (w_sel_digit),
    .o_seg (w_dec_seg)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Blank when this digit and everything above it is zero; digit 0 always shows.
  logic w_upper_zero;
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < DIGIT_COUNT; j++) begin
      if ((j >= int'(w_idx_next)) && (w_disp_next[j] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end
    end
    w_blank = (w_idx_next != '0) && w_upper_zero;
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_disp     <= '0;
      r_pending  <= 1'b0;
      r_anode    <= DIGIT_COUNT'(1);
      r_segments <= SEG_0;
      r_frame    <= 1'b0;
    end else begin
      r_presc   <= w_tc ? '0 : r_presc + 1'b1;
      r_idx     <= w_idx_next;
      r_disp    <= w_disp_next;
      r_frame   <= w_wrap;
      // Every wrap either commits or finds nothing pending, so it always clears.
      r_pending <= w_wrap ? 1'b0 : (r_pending | load);
      if (load) begin
        r_shadow <= digits;
      end
      if (w_tc) begin
        r_anode    <= DIGIT_COUNT'(1) << w_idx_next;
        r_segments <= w_blank ? SEG_BLANK : w_dec_seg;
      end
    end
  end

  assign anode    = r_anode;
  assign segments = r_segments;
  assign frame    = r_frame;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter DIGIT_COUNT, default 4, number of BCD digits and anode lines.
REQ-002 SHALL have parameter PRESCALE, default 1000, clk cycles each digit is lit (PRESCALE >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle strobe; captures digits on the same edge.
REQ-006 SHALL have port digits  input  [DIGIT_COUNT-1:0][3:0]  packed BCD from the converter; index 0 is least significant.
REQ-007 SHALL have port anode  output  DIGIT_COUNT  one-hot, active-high digit enable.
REQ-008 SHALL have port segments  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port frame  output  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-010 SHALL run a prescaler counting 0..PRESCALE-1, wrapping to 0; terminal count = PRESCALE-1.
REQ-011 SHALL advance scan index 0,1,...,DIGIT_COUNT-1,0 on each terminal count; no other transitions.
REQ-012 SHALL drive anode and segments from registers; both change on the edge after terminal count, never separately.
REQ-013 SHALL drive anode = 1 << index; exactly one bit is high at all times, including during reset.
REQ-014 SHALL decode BCD 0-9 to standard patterns (0=7'h3F, 1=7'h06, ..., 8=7'h7F, 9=7'h6F); codes 10-15 are blank (7'h00).
REQ-015 SHALL hold a shadow register and a pending flag; load writes shadow and sets pending.
REQ-016 SHALL commit shadow to the display register only when the index wraps to 0 and pending=1; pending then clears (tear-free frames).
REQ-017 SHALL let a second load before commit overwrite shadow; only the latest value is shown.
REQ-018 SHALL, when load coincides with the wrap edge, commit the new digits directly at that wrap and leave pending=0.
REQ-019 SHALL assert frame for exactly the cycle in which the registered index is 0 after a wrap.

Reset
REQ-020 SHALL, with rst=1, clear the prescaler, index, shadow, display register and pending, and set frame=0.
REQ-021 SHALL output anode=1 and segments=7'h3F on the cycle after rst is sampled high.
REQ-022 SHALL give rst priority over load; a load in the same cycle is discarded.
REQ-023 SHALL restart scanning at index 0 with a full PRESCALE period after rst deasserts.

Configuration
REQ-024 SHALL, with macro SEVEN_SEG_LZ_BLANK_EN defined, blank every digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-025 SHALL, without SEVEN_SEG_LZ_BLANK_EN, display every digit including leading zeros; nothing else differs.

Structure
REQ-026 SHALL place the segment pattern constants, the blank constant and a seg_t (logic [6:0]) typedef in shared package seven_seg_pkg.
REQ-027 SHALL implement the decoder as combinational sub-module bcd_to_7seg (4-bit in, seg_t out, blank for >9), instantiated once on the selected digit.

Verification (DIGIT_COUNT=4, PRESCALE=4)
REQ-028 SHALL check reset: rst 2 cycles -> anode=4'b0001, segments=7'h3F, frame=0; anode advances every 4 cycles after release.
REQ-029 SHALL check load and commit: load digits=16'h1234 mid-frame -> display unchanged until the wrap, then digit0..3 show 4,3,2,1 (7'h66,7'h4F,7'h5B,7'h06).
REQ-030 SHALL check coincident load: load 16'h0905 on the wrap edge -> 5 is shown immediately at index 0, pending=0.
REQ-031 SHALL check overwrite: loads of 16'h1111 then 16'h2222 in one frame -> next frame shows only 2s (7'h5B).
REQ-032 SHALL check blanking: 16'h0042 with SEVEN_SEG_LZ_BLANK_EN -> digits 3,2 show 7'h00; without the macro -> 7'h3F; 16'h0000 -> digit0 shows 7'h3F in both builds.
REQ-033 SHALL check invalid code and mid-scan reset: nibble 4'hC -> 7'h00; rst at index 2 -> anode=4'b0001 next cycle and display cleared to 0000.
